// File: rtl/layer4_output_serializer.sv
// Layer4 output serializer: buffers whole 32-channel pixel words in a small FIFO
// and drains them one channel word per valid/ready beat, tracking channel/pixel/frame position.
module layer4_output_serializer #(
  parameter int DATA_WIDHT = 32,
  parameter int CHANNELS   = 32,
  parameter int IMG_WIDHT  = 44,
  parameter int IMG_HEIGHT = 44,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DATA_WIDHT*CHANNELS-1:0] Data_In,
  input  logic                           Valid_In,
  input  logic                           Ready_In,
  output logic [DATA_WIDHT-1:0]          Data_Out,
  output logic                           Valid_Out,
  output logic [$clog2(CHANNELS)-1:0]    Channel_Idx,
  output logic                           Last_Channel,
  output logic                           End_Of_Frame,
  output logic                           Overflow
);

  localparam int CW     = $clog2(CHANNELS);
  localparam int PIXELS = IMG_WIDHT * IMG_HEIGHT;
  localparam int PW     = $clog2(PIXELS);
  localparam int AW     = $clog2(FIFO_DEPTH);
  localparam int NW     = AW + 1;

  localparam logic [CW-1:0] LAST_CH  = CW'(CHANNELS - 1);
  localparam logic [PW-1:0] LAST_PIX = PW'(PIXELS - 1);
  localparam logic [NW-1:0] DEPTH_N  = NW'(FIFO_DEPTH);
  localparam logic [NW-1:0] ONE_N    = NW'(1);

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_SEND  = 1'b1
  } state_t;

  state_t state_q, state_d;

  logic [DATA_WIDHT*CHANNELS-1:0] mem [FIFO_DEPTH];
  logic [DATA_WIDHT*CHANNELS-1:0] head;
  logic [AW-1:0]                  wr_ptr, rd_ptr;
  logic [NW-1:0]                  count;
  logic [CW-1:0]                  chan_cnt;
  logic [PW-1:0]                  pix_cnt;

  logic full, beat, pop, push, drop;

  assign full = (count == DEPTH_N);
  assign beat = Valid_Out & Ready_In;
  assign pop  = beat & (chan_cnt == LAST_CH);
  // A full FIFO still takes a new pixel when the head leaves in the same cycle.
  assign push = Valid_In & (~full | pop);
  assign drop = Valid_In & full & ~pop;

  // NOTE: every signal written here gets a default first, so no path leaves it
  // unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: if (push) state_d = S_SEND;
      S_SEND:  if (pop && (count == ONE_N) && !push) state_d = S_EMPTY;
      default: state_d = S_EMPTY;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= S_EMPTY;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      chan_cnt <= '0;
      pix_cnt  <= '0;
      Overflow <= 1'b0;
    end else begin
      state_q <= state_d;
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + ONE_N;
        2'b01:   count <= count - ONE_N;
        default: count <= count;
      endcase
      if (beat) chan_cnt <= pop ? '0 : chan_cnt + CW'(1);
      if (pop)  pix_cnt  <= (pix_cnt == LAST_PIX) ? '0 : pix_cnt + PW'(1);
      if (drop) Overflow <= 1'b1;
    end
  end

  // NOTE: the storage array is deliberately not reset; pointers and count define
  // which entries are live, and empty-state output is gated below.
  always_ff @(posedge clk) begin
    if (rst && push) mem[wr_ptr] <= Data_In;
  end

  assign head         = mem[rd_ptr];
  assign Valid_Out    = (state_q == S_SEND);
  assign Data_Out     = Valid_Out ? head[chan_cnt*DATA_WIDHT +: DATA_WIDHT] : '0;
  assign Channel_Idx  = chan_cnt;
  assign Last_Channel = Valid_Out & (chan_cnt == LAST_CH);
  assign End_Of_Frame = Last_Channel & (pix_cnt == LAST_PIX);

endmodule

// File: doc/layer4_output_serializer.md
Name: layer4_output_serializer

Overview:
- Sink end of the Layer4 streaming output. Accepts one 32-channel pixel per Valid_In pulse (DATA_WIDHT*32 bits, no backpressure upstream) into a small pixel FIFO.
- Drains the FIFO one channel word per beat onto a narrow valid/ready stream for the feature-map writeback path.
- Tracks channel, pixel and frame position, and flags dropped pixels.

Parameters:
- DATA_WIDHT, 32, bits per channel word (IEEE-754 single).
- CHANNELS, 32, channels per pixel word.
- IMG_WIDHT, 44, pixels per row.
- IMG_HEIGHT, 44, rows per frame.
- FIFO_DEPTH, 4, pixel words buffered; power of two, ≥2.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-low.
- Data_In  in  DATA_WIDHT*CHANNELS  pixel word; channel k at [DATA_WIDHT*(k+1)-1:DATA_WIDHT*k].
- Valid_In  in  1  pixel word present this cycle.
- Ready_In  in  1  downstream accepts Data_Out this cycle.
- Data_Out  out  DATA_WIDHT  current channel word.
- Valid_Out  out  1  Data_Out valid.
- Channel_Idx  out  $clog2(CHANNELS)  channel index of Data_Out.
- Last_Channel  out  1  Data_Out is channel CHANNELS-1.
- End_Of_Frame  out  1  Data_Out is last channel of pixel IMG_WIDHT*IMG_HEIGHT-1.
- Overflow  out  1  sticky, a pixel was dropped.

Behaviour:
- Reset (rst=0 at rising edge): clear FIFO pointers and count, channel counter, pixel counter and Overflow. During and after reset, Valid_Out, Last_Channel, End_Of_Frame, Overflow and Channel_Idx are 0. Data_Out is 0 while empty.
- Reset mid-frame discards all buffered pixels and restarts at pixel 0, channel 0.
- Push: when Valid_In=1 and the FIFO is not full, Data_In is written at the write pointer.
- Pop: a pixel is popped when beat = Valid_Out & Ready_In occurs with channel counter = CHANNELS-1.
- Full with simultaneous push and pop: the push is accepted and the count is unchanged.
- Full with push and no pop: the pixel is dropped, Overflow is set to 1 the next cycle and stays 1 until reset. FIFO contents and pointers are unchanged.
- Latency: a pixel pushed at edge N is visible (Valid_Out=1, channel 0) in the cycle after edge N, provided the FIFO was empty.
- Valid_Out = FIFO not empty.
- Data_Out is the combinational slice of the FIFO head selected by the channel counter. Channel 0 is sent first.
- Data_Out and Channel_Idx hold stable while Valid_Out=1 and Ready_In=0.
- Channel counter:
  - Increments on each beat.
  - Wraps CHANNELS-1 → 0 on the popping beat.
  - Holds when there is no beat.
- Pixel counter:
  - Increments on each pop.
  - Wraps IMG_WIDHT*IMG_HEIGHT-1 → 0.
  - Width is $clog2(IMG_WIDHT*IMG_HEIGHT).
- Last_Channel = Valid_Out & (channel counter = CHANNELS-1).
- End_Of_Frame = Last_Channel & (pixel counter = IMG_WIDHT*IMG_HEIGHT-1).
- Pointers wrap modulo FIFO_DEPTH. Full/empty are derived from an occupancy count of width $clog2(FIFO_DEPTH)+1.
- Control state machine:
  - EMPTY (Valid_Out=0): → SEND on push.
  - SEND: → EMPTY on pop when count=1 and no simultaneous push; otherwise stays in SEND.
  - FULL is a flag, not a state.
- Sustained throughput is one pixel per CHANNELS cycles with Ready_In held at 1. Upstream bursts longer than FIFO_DEPTH pixels inside that window overflow.

Test Plan:
- Single pixel, channel k = 32'h3F800000+k, Ready_In=1 → Valid_Out from the next cycle for 32 cycles. Data_Out runs 3F800000..3F80001F, Channel_Idx 0..31, Last_Channel only on beat 31, then Valid_Out=0.
- Same pixel with Ready_In toggling 1/0 every cycle → 32 beats over 63 cycles. Data_Out and Channel_Idx hold during Ready_In=0, and the order is unchanged.
- Push 5 pixels on consecutive cycles, FIFO_DEPTH=4, Ready_In=0 → pixels 0-3 buffered, pixel 4 dropped, Overflow=1 from the next cycle. Draining yields exactly pixels 0-3 (128 beats).
- FIFO full and pixel 0 on beat 31 with Valid_In=1 in the same cycle → push accepted, no Overflow, count stays 4.
- Stream 1936 pixels with Ready_In=1 and Valid_In every 32 cycles → End_Of_Frame high exactly once, on beat 61951. The pixel counter wraps and the next pixel starts at 0.
- Assert rst=0 for one cycle at pixel 10, channel 7 → all outputs 0 next cycle, FIFO empty. The next push restarts at channel 0, and End_Of_Frame arrives after 1936 new pixels.
